// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Multicycle MIPS control sequencer: walks the shared datapath through one
// microstep per clock and drives every mux select and write enable from the
// current state. Memory steps (FETCH, MEMRD, MEMWR) hold until mem_ready.
// Optional feature macro: MIPS_CTRL_BNE_EN adds bne (opcode 000101) support;
// without it that opcode takes the illegal path.
// Outputs are combinational from state and selected inputs; while reset is
// high every output except state is forced to 0.

module mips_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_control,
  output logic [1:0]         pc_src,
  output logic               pc_en,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_RTYPEEX = 4'd6,
    ST_RTYPEWB = 4'd7,
    ST_BEQEX   = 4'd8,
    ST_ADDIEX  = 4'd9,
    ST_ADDIWB  = 4'd10,
    ST_JEX     = 4'd11,
    ST_BNEEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MIPS_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // R-type ALU operation from funct; unknown funct codes fall back to add.
  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    logic [2:0] op;
    case (f)
      6'b100000: op = ALU_ADD;
      6'b100010: op = ALU_SUB;
      6'b100100: op = ALU_AND;
      6'b100101: op = ALU_OR;
      6'b101010: op = ALU_SLT;
      default:   op = ALU_ADD;
    endcase
    return op;
  endfunction

  state_t state_r;
  state_t next_state_s;

  // State register: the only storage in the controller.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  assign state = STATE_W'(state_r);

  // Next-state and control decode; reset gates every control to 0.
  always_comb begin
    next_state_s = ST_FETCH;
    mem_req      = 1'b0;
    iord         = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_control  = 3'b000;
    pc_src       = 2'b00;
    pc_en        = 1'b0;
    illegal      = 1'b0;

    if (reset) begin
      next_state_s = ST_FETCH;
    end else begin
      case (state_r)
        ST_FETCH: begin
          mem_req     = 1'b1;
          iord        = 1'b0;
          alu_src_a   = 1'b0;
          alu_src_b   = 2'b01;
          alu_control = ALU_ADD;
          if (mem_ready) begin
            ir_write     = 1'b1;
            pc_src       = 2'b00;
            pc_en        = 1'b1;
            next_state_s = ST_DECODE;
          end else begin
            ir_write     = 1'b0;
            pc_en        = 1'b0;
            next_state_s = ST_FETCH;
          end
        end

        ST_DECODE: begin
          // Speculatively form the branch target into ALUOut.
          alu_src_a   = 1'b0;
          alu_src_b   = 2'b11;
          alu_control = ALU_ADD;
          case (opcode)
            OP_LW, OP_SW: next_state_s = ST_MEMADR;
            OP_RTYPE:     next_state_s = ST_RTYPEEX;
            OP_BEQ:       next_state_s = ST_BEQEX;
            OP_ADDI:      next_state_s = ST_ADDIEX;
            OP_J:         next_state_s = ST_JEX;
`ifdef MIPS_CTRL_BNE_EN
            OP_BNE:       next_state_s = ST_BNEEX;
`endif
            default: begin
              illegal      = 1'b1;
              next_state_s = ST_FETCH;
            end
          endcase
        end

        ST_MEMADR: begin
          alu_src_a   = 1'b1;
          alu_src_b   = 2'b10;
          alu_control = ALU_ADD;
          if (opcode == OP_LW) begin
            next_state_s = ST_MEMRD;
          end else begin
            next_state_s = ST_MEMWR;
          end
        end

        ST_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            next_state_s = ST_MEMWB;
          end else begin
            next_state_s = ST_MEMRD;
          end
        end

        ST_MEMWB: begin
          reg_dst      = 1'b0;
          mem_to_reg   = 1'b1;
          reg_write    = 1'b1;
          next_state_s = ST_FETCH;
        end

        ST_MEMWR: begin
          // Write strobe is held for every cycle the memory is stalling.
          mem_req   = 1'b1;
          iord      = 1'b1;
          mem_write = 1'b1;
          if (mem_ready) begin
            next_state_s = ST_FETCH;
          end else begin
            next_state_s = ST_MEMWR;
          end
        end

        ST_RTYPEEX: begin
          alu_src_a    = 1'b1;
          alu_src_b    = 2'b00;
          alu_control  = rtype_alu(funct);
          next_state_s = ST_RTYPEWB;
        end

        ST_RTYPEWB: begin
          reg_dst      = 1'b1;
          mem_to_reg   = 1'b0;
          reg_write    = 1'b1;
          next_state_s = ST_FETCH;
        end

        ST_BEQEX: begin
          alu_src_a    = 1'b1;
          alu_src_b    = 2'b00;
          alu_control  = ALU_SUB;
          pc_src       = 2'b01;
          pc_en        = zero;
          next_state_s = ST_FETCH;
        end

        ST_ADDIEX: begin
          alu_src_a    = 1'b1;
          alu_src_b    = 2'b10;
          alu_control  = ALU_ADD;
          next_state_s = ST_ADDIWB;
        end

        ST_ADDIWB: begin
          reg_dst      = 1'b0;
          mem_to_reg   = 1'b0;
          reg_write    = 1'b1;
          next_state_s = ST_FETCH;
        end

        ST_JEX: begin
          pc_src       = 2'b10;
          pc_en        = 1'b1;
          next_state_s = ST_FETCH;
        end

`ifdef MIPS_CTRL_BNE_EN
        ST_BNEEX: begin
          alu_src_a    = 1'b1;
          alu_src_b    = 2'b00;
          alu_control  = ALU_SUB;
          pc_src       = 2'b01;
          pc_en        = ~zero;
          next_state_s = ST_FETCH;
        end
`endif

        default: begin
          // Unused codes recover to FETCH with all controls idle.
          next_state_s = ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl.
// Each instruction is expanded into a per-cycle list of expected microsteps
// from the instruction-level rules; a driver applies the inputs cycle by cycle
// and pushes the expectation, and a monitor compares on the falling edge.

module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'b000000;
  logic [5:0] funct = 6'b000000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, pc_en, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .pc_src(pc_src), .pc_en(pc_en),
    .illegal(illegal), .state(state)
  );

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  logic [5:0] fn_tab  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] alu_tab [5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic        zr;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [3:0]  st;
    logic [16:0] ctl;
  } step_t;

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] ctl;
  } exp_t;

  step_t plan_q[$];
  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;

  // Control vector in the order {mem_req,iord,mem_write,ir_write,reg_dst,
  // mem_to_reg,reg_write,alu_src_a,alu_src_b,alu_control,pc_src,pc_en,illegal}.
  function automatic logic [16:0] ctl_v(input logic mreq, input logic io, input logic mw,
                                        input logic irw, input logic rd, input logic m2r,
                                        input logic rw, input logic asa, input logic [1:0] asb,
                                        input logic [2:0] alu, input logic [1:0] pcs,
                                        input logic pce, input logic ill);
    return {mreq, io, mw, irw, rd, m2r, rw, asa, asb, alu, pcs, pce, ill};
  endfunction

  function automatic logic [16:0] fetch_ctl(input logic rdy);
    return ctl_v(1'b1, 1'b0, 1'b0, rdy, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b010, 2'b00, rdy, 1'b0);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit legal_op(input logic [5:0] op);
    bit ok;
    ok = (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_BEQ) ||
         (op == OP_ADDI) || (op == OP_J);
`ifdef MIPS_CTRL_BNE_EN
    ok = ok || (op == OP_BNE);
`endif
    return ok;
  endfunction

  function automatic logic [2:0] exp_rtype_alu(input logic [5:0] fn);
    logic [2:0] r;
    r = 3'b010;
    for (int i = 0; i < 5; i++) begin
      if (fn_tab[i] == fn) r = alu_tab[i];
    end
    return r;
  endfunction

  task automatic push_step(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                           input logic zr, input logic [3:0] st, input logic [16:0] ctl);
    step_t s;
    s.rst = 1'b0; s.rdy = rdy; s.zr = zr; s.op = op; s.fn = fn; s.st = st; s.ctl = ctl;
    plan_q.push_back(s);
  endtask

  task automatic push_reset();
    step_t s;
    s.rst = 1'b1; s.rdy = rbit(); s.zr = rbit(); s.op = 6'($urandom_range(0, 63));
    s.fn = 6'($urandom_range(0, 63)); s.st = 4'd0; s.ctl = 17'd0;
    plan_q.push_back(s);
  endtask

  // Expand one instruction into its expected cycle-by-cycle behaviour.
  task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                            input int mw, input logic zr);
    logic [16:0] rd_ctl, wr_ctl;
    rd_ctl = ctl_v(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
    wr_ctl = ctl_v(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < fw; i++) push_step(op, fn, 1'b0, rbit(), 4'd0, fetch_ctl(1'b0));
    push_step(op, fn, 1'b1, rbit(), 4'd0, fetch_ctl(1'b1));
    push_step(op, fn, rbit(), rbit(), 4'd1,
              ctl_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b010, 2'b00, 1'b0,
                    !legal_op(op)));
    if (!legal_op(op)) return;
    if (op == OP_LW || op == OP_SW) begin
      push_step(op, fn, rbit(), rbit(), 4'd2,
                ctl_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b010, 2'b00, 1'b0, 1'b0));
      for (int i = 0; i < mw; i++)
        push_step(op, fn, 1'b0, rbit(), (op == OP_LW) ? 4'd3 : 4'd5, (op == OP_LW) ? rd_ctl : wr_ctl);
      push_step(op, fn, 1'b1, rbit(), (op == OP_LW) ? 4'd3 : 4'd5, (op == OP_LW) ? rd_ctl : wr_ctl);
      if (op == OP_LW)
        push_step(op, fn, rbit(), rbit(), 4'd4,
                  ctl_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0));
    end else if (op == OP_R) begin
      push_step(op, fn, rbit(), rbit(), 4'd6,
                ctl_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, exp_rtype_alu(fn), 2'b00, 1'b0, 1'b0));
      push_step(op, fn, rbit(), rbit(), 4'd7,
                ctl_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0));
    end else if (op == OP_BEQ) begin
      push_step(op, fn, rbit(), zr, 4'd8,
                ctl_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b110, 2'b01, zr, 1'b0));
    end else if (op == OP_ADDI) begin
      push_step(op, fn, rbit(), rbit(), 4'd9,
                ctl_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b010, 2'b00, 1'b0, 1'b0));
      push_step(op, fn, rbit(), rbit(), 4'd10,
                ctl_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0));
    end else if (op == OP_J) begin
      push_step(op, fn, rbit(), rbit(), 4'd11,
                ctl_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b10, 1'b1, 1'b0));
    end else begin
      push_step(op, fn, rbit(), zr, 4'd12,
                ctl_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b110, 2'b01, ~zr, 1'b0));
    end
  endtask

  // Planning, then cycle-by-cycle driving with expectations queued as issued.
  initial begin
    logic [5:0] op, fn;
    int base, k, cls, fw, mw;

    for (int i = 0; i < 5; i++) push_reset();
    plan_instr(OP_LW, 6'b000000, 0, 0, 1'b0);
    plan_instr(OP_SW, 6'b000000, 0, 3, 1'b0);
    plan_instr(OP_R, 6'b100010, 0, 0, 1'b0);
    plan_instr(OP_BEQ, 6'b000000, 0, 0, 1'b1);
    plan_instr(OP_BEQ, 6'b000000, 0, 0, 1'b0);
    plan_instr(OP_BNE, 6'b000000, 0, 0, 1'b0);
    plan_instr(OP_BNE, 6'b000000, 0, 0, 1'b1);
    plan_instr(OP_J, 6'b000000, 1, 0, 1'b0);
    plan_instr(OP_ADDI, 6'b000000, 0, 0, 1'b0);
    plan_instr(OP_LW, 6'b000000, 2, 2, 1'b0);
    plan_instr(6'b111111, 6'b000000, 0, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      cls = int'($urandom_range(0, 7));
      case (cls)
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_R;
        3: op = OP_BEQ;
        4: op = OP_ADDI;
        5: op = OP_J;
        6: op = OP_BNE;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (legal_op(op) || op == OP_BNE) op = 6'($urandom_range(0, 63));
        end
      endcase
      if ($urandom_range(0, 3) != 0) fn = fn_tab[$urandom_range(0, 4)];
      else fn = 6'($urandom_range(0, 63));
      fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      mw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      base = plan_q.size();
      plan_instr(op, fn, fw, mw, rbit());
      if ($urandom_range(0, 9) == 0 && (plan_q.size() - base) >= 2) begin
        k = int'($urandom_range(base + 1, plan_q.size() - 1));
        while (plan_q.size() > k) plan_q.delete(plan_q.size() - 1);
        push_reset();
      end
    end

    foreach (plan_q[i]) begin
      exp_t e;
      @(posedge clk);
      #1;
      reset     = plan_q[i].rst;
      mem_ready = plan_q[i].rdy;
      zero      = plan_q[i].zr;
      opcode    = plan_q[i].op;
      funct     = plan_q[i].fn;
      e.st  = plan_q[i].st;
      e.ctl = plan_q[i].ctl;
      sb_q.push_back(e);
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d expected=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Monitor: compare DUT state and controls against the oldest expectation.
  initial begin
    exp_t        e;
    logic [16:0] got;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        got = {mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_control, pc_src, pc_en, illegal};
        checks++;
        if (state !== e.st) begin
          errors++;
          $display("FAIL state t=%0t got=%0d expected=%0d", $time, state, e.st);
        end
        checks++;
        if (got !== e.ctl) begin
          errors++;
          $display("FAIL ctl t=%0t state=%0d got=%05h expected=%05h", $time, e.st, got, e.ctl);
        end
      end
    end
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control unit that sequences the shared MIPS datapath (single memory, single ALU, PC/IR/register-file write enables) one microstep per clock. Sits inside `MIPS_Top` beside the datapath; decodes `opcode`/`funct` from the IR and drives every mux select and write enable. Memory accesses use a ready handshake so the same sequencer works with single-cycle or wait-stated memory.

## Interface
Parameters:
- `STATE_W`, 4, width of the state register and `state` debug port.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces state to FETCH.
- `opcode`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completed the current access this cycle.
- `mem_req`  out  1  memory access requested.
- `iord`  out  1  0 = PC addresses memory, 1 = ALUOut.
- `mem_write`  out  1  memory write strobe.
- `ir_write`  out  1  load IR.
- `reg_dst`  out  1  1 = rd, 0 = rt.
- `mem_to_reg`  out  1  1 = MDR, 0 = ALUOut.
- `reg_write`  out  1  register-file write enable.
- `alu_src_a`  out  1  0 = PC, 1 = A.
- `alu_src_b`  out  2  00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- `alu_control`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pc_en`  out  1  PC load enable.
- `illegal`  out  1  one-cycle pulse on unsupported opcode.
- `state`  out  `STATE_W`  current state code.

## Operation
- States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, BNEEX 12.
- FETCH: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, add. If `mem_ready`: `ir_write`=1, `pc_src`=00, `pc_en`=1, next DECODE; else stay, with `ir_write`/`pc_en` held at 0.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, add (branch target to ALUOut). Next by opcode: 100011/101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX; 000101 -> BNEEX (macro only); else `illegal`=1, next FETCH.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, add. lw -> MEMRD, sw -> MEMWR.
- MEMRD: `mem_req`=1, `iord`=1; wait for `mem_ready`, then MEMWB.
- MEMWB: `reg_dst`=0, `mem_to_reg`=1, `reg_write`=1 -> FETCH.
- MEMWR: `mem_req`=1, `iord`=1, `mem_write`=1 every cycle until `mem_ready`, then FETCH.
- RTYPEEX: `alu_src_a`=1, `alu_src_b`=00; `alu_control` from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, other funct -> add. Next RTYPEWB.
- RTYPEWB: `reg_dst`=1, `mem_to_reg`=0, `reg_write`=1 -> FETCH.
- BEQEX: `alu_src_a`=1, `alu_src_b`=00, sub, `pc_src`=01, `pc_en`=`zero` -> FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, add -> ADDIWB. ADDIWB: `reg_dst`=0, `mem_to_reg`=0, `reg_write`=1 -> FETCH.
- JEX: `pc_src`=10, `pc_en`=1 -> FETCH.
- Any unlisted output is 0 in a given state; unused state codes (13–15) go to FETCH with all outputs 0.

## Timing
- While `reset`=1: state = FETCH; every output except `state` forced to 0 (no write on reset). First FETCH access is on the first edge after deassertion.
- Outputs are combinational from `state` (plus `mem_ready`, `zero`, `opcode`, and `funct`, where noted above); the state register is the only storage.
- Cycle counts with `mem_ready` tied to 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, bne 3, illegal 2. Each wait cycle adds one.
- `mem_ready` is sampled only in FETCH, MEMRD, and MEMWR; it is ignored elsewhere.
- Reset asserted mid-instruction: all outputs go to 0 immediately (asynchronously), and the partial instruction is abandoned.

## Configuration
- `MIPS_CTRL_BNE_EN` defined: opcode 000101 decodes to BNEEX (sub, `pc_src`=01, `pc_en`=~`zero`) -> FETCH.
- Not defined: BNEEX is unreachable and 000101 takes the illegal path.

## Test plan
- Reset held 50 ns, then released with `mem_ready`=1 -> `state`=0 and all outputs 0 during reset; first edge after release gives `ir_write`=1, `pc_en`=1.
- lw (opcode 100011), `mem_ready`=1 -> state sequence 0,1,2,3,4,0; `reg_write`=1 with `mem_to_reg`=1 only in state 4.
- sw with `mem_ready` low for 3 cycles in MEMWR -> `mem_write`=1 for exactly 4 cycles, then FETCH.
- R-type funct 100010 -> `alu_control`=110 in RTYPEEX; `reg_dst`=1, `reg_write`=1 in RTYPEWB; 4 cycles total.
- beq with `zero`=1 -> `pc_en`=1 and `pc_src`=01 in BEQEX; with `zero`=0 -> `pc_en`=0.
- opcode 000101: with macro, `zero`=0 -> `pc_en`=1; without macro -> `illegal` pulses for 1 cycle in DECODE, then FETCH.
